// File: rtl/qpi_psram_ctrl.sv
// qpi_psram_ctrl: single-word QPI master for an LY68L6400-class PSRAM.
// Reads use fast read 0xEB, writes use quad write 0x38. SCLK runs at clk/2;
// every bus output is registered and changes only as SCLK falls.
// Optional feature macro: PSRAM_WSTRB_EN (byte strobes, one burst per strobe run).
module qpi_psram_ctrl #(
    parameter int DUMMY_CLKS = 6,
    parameter int DESEL_CLKS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [22:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef PSRAM_WSTRB_EN
    input  logic [3:0]  req_wstrb,
`endif
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        psram_sclk,
    output logic        psram_ncs,
    output logic [3:0]  psram_dout,
    output logic        psram_dq_oe,
    input  logic [3:0]  psram_din
);

    localparam int CW = 8;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_RESP, S_DESEL
    } state_t;

    state_t         state, state_d;
    logic [CW-1:0]  cnt;
    logic           wr_q;
    logic [20:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [3:0]     pend;
    logic [2:0]     wlast;
    logic [59:0]    shreg;
    logic [31:0]    rsh;
    logic [3:0]     strb;
    logic [1:0]     first;
    logic [3:0]     run;
    logic           stop;
    logic [31:0]    wsh;
    logic [7:0]     cmd_byte;
    logic           ncs_d, sclk_d, oe_d, rspv_d;
    logic [3:0]     dout_d;
    logic           unused_bits;

    // Word alignment: the low address bits never reach the bus.
    assign unused_bits = &{1'b0, req_addr[1:0]};

`ifdef PSRAM_WSTRB_EN
    assign strb = req_wstrb;
`else
    assign strb = 4'hf;
`endif

    // Little-endian word to bus order: byte 0 in the top byte so it shifts out first.
    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    assign cmd_byte  = wr_q ? 8'h38 : 8'hEB;
    assign req_ready = (state == S_IDLE);

    // Lowest pending lane and the contiguous run of strobes starting there.
    always_comb begin
        first = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (pend[i]) first = 2'(i);
        run  = 4'h0;
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) >= first && !stop) begin
                if (pend[i]) run[i] = 1'b1;
                else         stop   = 1'b1;
            end
        end
        wsh = wdata_q >> {first, 3'b000};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_DESEL;
        else     state <= state_d;
    end

    // Next-state logic; bus states advance only on the SCLK falling half.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (req_valid) state_d = S_START;
            S_START: state_d = (wr_q && pend == 4'h0) ? S_IDLE : S_CMD;
            S_CMD:   if (psram_sclk && cnt == CW'(1)) state_d = S_ADDR;
            S_ADDR:  if (psram_sclk && cnt == CW'(5))
                         state_d = wr_q ? S_WDATA : ((DUMMY_CLKS == 0) ? S_RDATA : S_DUMMY);
            S_DUMMY: if (psram_sclk && cnt == CW'(DUMMY_CLKS - 1)) state_d = S_RDATA;
            S_RDATA: if (psram_sclk && cnt == CW'(7)) state_d = S_RESP;
            S_WDATA: if (psram_sclk && cnt == {5'd0, wlast}) state_d = S_RESP;
            S_RESP:  state_d = S_DESEL;
            S_DESEL: if (!psram_sclk && cnt == CW'(DESEL_CLKS))
                         state_d = (pend != 4'h0) ? S_START : S_IDLE;
            default: state_d = S_DESEL;
        endcase
    end

    // Next values of the registered bus outputs and response strobe.
    always_comb begin
        ncs_d  = psram_ncs;
        sclk_d = psram_sclk;
        dout_d = psram_dout;
        oe_d   = psram_dq_oe;
        rspv_d = 1'b0;
        case (state)
            S_START: begin
                if (wr_q && pend == 4'h0) begin
                    rspv_d = 1'b1;
                end else begin
                    ncs_d  = 1'b0;
                    sclk_d = 1'b0;
                    dout_d = cmd_byte[7:4];
                    oe_d   = 1'b1;
                end
            end
            S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA: begin
                if (!psram_sclk) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    if (psram_dq_oe) dout_d = shreg[59:56];
                    if (state_d == S_DUMMY || state_d == S_RDATA) begin
                        oe_d   = 1'b0;
                        dout_d = 4'h0;
                    end
                    if (state_d == S_RESP) begin
                        ncs_d  = 1'b1;
                        oe_d   = 1'b0;
                        dout_d = 4'h0;
                        rspv_d = (pend == 4'h0);
                    end
                end
            end
            S_RESP:  sclk_d = 1'b1;
            S_DESEL: begin
                ncs_d = 1'b1;
                oe_d  = 1'b0;
                if (psram_sclk)                    sclk_d = 1'b0;
                else if (cnt != CW'(DESEL_CLKS))   sclk_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            psram_ncs   <= 1'b1;
            psram_sclk  <= 1'b0;
            psram_dout  <= 4'h0;
            psram_dq_oe <= 1'b0;
            rsp_valid   <= 1'b0;
        end else begin
            psram_ncs   <= ncs_d;
            psram_sclk  <= sclk_d;
            psram_dout  <= dout_d;
            psram_dq_oe <= oe_d;
            rsp_valid   <= rspv_d;
        end
    end

    // Request latch, nibble shifter, phase counter and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pend      <= 4'h0;
            wlast     <= 3'd7;
            shreg     <= '0;
            rsh       <= '0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    wr_q    <= req_write;
                    addr_q  <= req_addr[22:2];
                    wdata_q <= req_wdata;
                    pend    <= req_write ? strb : 4'h0;
                end
                S_START: begin
                    cnt   <= '0;
                    shreg <= {cmd_byte[3:0], 1'b0, addr_q, wr_q ? first : 2'd0, bswap(wsh)};
                    wlast <= wr_q ? 3'($countones(run) * 2 - 1) : 3'd7;
                    pend  <= pend & ~run;
                end
                S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA: begin
                    if (psram_sclk) begin
                        cnt <= (state_d != state) ? '0 : cnt + 1'b1;
                        if (psram_dq_oe) shreg <= {shreg[55:0], 4'h0};
                        if (state == S_RDATA && state_d == S_RESP) rsp_rdata <= bswap(rsh);
                    end else if (state == S_RDATA) begin
                        rsh <= {rsh[27:0], psram_din};
                    end
                end
                S_RESP:  cnt <= '0;
                S_DESEL: if (psram_sclk) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qpi_psram_ctrl.sv
// Directed bench for qpi_psram_ctrl with a behavioural QPI PSRAM model.
module tb_qpi_psram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [22:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = 4'hf;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        psram_sclk, psram_ncs, psram_dq_oe;
    logic [3:0]  psram_dout;
    logic [3:0]  psram_din = 4'h0;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    qpi_psram_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef PSRAM_WSTRB_EN
        .req_wstrb(req_wstrb),
`endif
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .psram_sclk(psram_sclk), .psram_ncs(psram_ncs), .psram_dout(psram_dout),
        .psram_dq_oe(psram_dq_oe), .psram_din(psram_din)
    );

    always #5 clk = ~clk;

    // Edge index: after posedge n, cyc == n.
    int cyc = 0;
    int t_acc = 0, n_acc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) begin
            t_acc <= cyc + 1;
            n_acc <= n_acc + 1;
        end
    end

    int t_rsp = 0, n_rsp = 0;
    always @(negedge clk) if (rsp_valid) begin
        t_rsp = cyc;
        n_rsp = n_rsp + 1;
    end

    // PSRAM model, evaluated mid-cycle so it never races the DUT registers.
    logic [7:0]  mem [4096];
    logic [3:0]  log_mem [512];
    int          log_n = 0;
    int          desel_rise = 0;
    int          rcnt = 0;
    int          idx;
    logic [31:0] ca = '0;
    logic [7:0]  mcmd = '0;
    logic [23:0] maddr = '0;
    logic [3:0]  hi = '0;
    logic [7:0]  b;
    logic        sclk_prev = 1'b0;
    initial for (int i = 0; i < 4096; i++) mem[i] = 8'(i);

    always @(negedge clk) begin
        if (psram_ncs) begin
            rcnt = 0;
            if (psram_sclk && !sclk_prev) desel_rise = desel_rise + 1;
        end else if (psram_sclk && !sclk_prev) begin
            rcnt = rcnt + 1;
            if (rcnt <= 8) begin
                ca = {ca[27:0], psram_dout};
                log_mem[log_n % 512] = psram_dout;
                log_n = log_n + 1;
                if (rcnt == 2) mcmd = ca[7:0];
                if (rcnt == 8) maddr = ca[23:0];
            end else if (mcmd == 8'h38 && rcnt <= 16) begin
                idx = rcnt - 9;
                log_mem[log_n % 512] = psram_dout;
                log_n = log_n + 1;
                if (idx % 2 == 0) hi = psram_dout;
                else mem[(int'(maddr) + idx / 2) % 4096] = {hi, psram_dout};
            end
        end else if (!psram_sclk && sclk_prev && mcmd == 8'hEB && rcnt >= 14 && rcnt < 22) begin
            idx = rcnt - 14;
            b = mem[(int'(maddr) + idx / 2) % 4096];
            psram_din = (idx % 2 == 0) ? b[7:4] : b[3:0];
        end
        sclk_prev = psram_sclk;
    end

    // Present one request from a negedge; returns at the negedge where cyc == accept edge.
    task automatic issue(input logic wr, input logic [22:0] a, input logic [31:0] d, input logic [3:0] s);
        int  n0 = n_acc;
        bit  ok = 1'b0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (n_acc != n0) ok = 1'b1;
        end
        req_valid = 1'b0;
        chk_cnt++;
        if (!ok) $display("FAIL accept_timeout: accepted=%0d required=1", ok);
        else pass_cnt++;
    endtask

    task automatic wait_rsp(input int r0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (n_rsp != r0) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int  pulses = 0;
        bit  oe_seen = 1'b0, ncs_low = 1'b0, ok = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++; if ({psram_ncs, psram_sclk, psram_dout, psram_dq_oe} !== 7'b1000000) $display("FAIL reset_bus: got %b required 1000000", {psram_ncs, psram_sclk, psram_dout, psram_dq_oe}); else pass_cnt++;
        chk_cnt++; if ({rsp_valid, req_ready} !== 2'b00) $display("FAIL reset_hs: got %b required 00", {rsp_valid, req_ready}); else pass_cnt++;
        chk_cnt++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h required 0", rsp_rdata); else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (psram_sclk) pulses++;
            if (psram_dq_oe) oe_seen = 1'b1;
            if (!psram_ncs) ncs_low = 1'b1;
            if (req_ready) ok = 1'b1;
        end
        chk_cnt++; if (!ok) $display("FAIL reset_ready: ready=%0d required 1", ok); else pass_cnt++;
        chk_cnt++; if (pulses != 1) $display("FAIL reset_desel_pulses: got %0d required 1", pulses); else pass_cnt++;
        chk_cnt++; if (oe_seen || ncs_low) $display("FAIL reset_idle_bus: oe=%0d ncs_low=%0d required 0 0", oe_seen, ncs_low); else pass_cnt++;
    endtask

    task automatic test_read();
        logic [3:0] en [8];
        int  n0 = log_n, r0 = n_rsp, t0;
        bit  ok;
        en = '{4'hE, 4'hB, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
        issue(1'b0, 23'h000100, 32'h0, 4'hf);
        t0 = t_acc;
        @(negedge clk);
        chk_cnt++; if ({psram_ncs, psram_sclk, psram_dout, psram_dq_oe} !== 7'b0011101) $display("FAIL read_first_nibble: got %b required 0011101", {psram_ncs, psram_sclk, psram_dout, psram_dq_oe}); else pass_cnt++;
        wait_rsp(r0, ok);
        chk_cnt++; if (!ok || t_rsp - t0 != 45) $display("FAIL read_rsp_time: got T+%0d required T+45", t_rsp - t0); else pass_cnt++;
        chk_cnt++; if (rsp_rdata !== 32'h03020100) $display("FAIL read_data: got %h required 03020100", rsp_rdata); else pass_cnt++;
        wait_ready(ok);
        chk_cnt++; if (!ok || cyc - t0 != 48) $display("FAIL read_ready_time: got T+%0d required T+48", cyc - t0); else pass_cnt++;
        chk_cnt++; if (n_rsp - r0 != 1) $display("FAIL read_rsp_count: got %0d required 1", n_rsp - r0); else pass_cnt++;
        chk_cnt++; if (log_n - n0 != 8) $display("FAIL read_nibble_count: got %0d required 8", log_n - n0); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            chk_cnt++; if (log_mem[(n0 + i) % 512] !== en[i]) $display("FAIL read_nibble[%0d]: got %h required %h", i, log_mem[(n0 + i) % 512], en[i]); else pass_cnt++;
        end
    endtask

    task automatic test_write_read();
        logic [3:0] en [16];
        int  n0 = log_n, r0 = n_rsp, t0;
        bit  ok;
        en = '{4'h3, 4'h8, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0,
               4'hE, 4'hF, 4'hB, 4'hE, 4'hA, 4'hD, 4'hD, 4'hE};
        issue(1'b1, 23'h000200, 32'hDEADBEEF, 4'hf);
        t0 = t_acc;
        wait_rsp(r0, ok);
        chk_cnt++; if (!ok || t_rsp - t0 != 33) $display("FAIL write_rsp_time: got T+%0d required T+33", t_rsp - t0); else pass_cnt++;
        wait_ready(ok);
        chk_cnt++; if (!ok || cyc - t0 != 36) $display("FAIL write_ready_time: got T+%0d required T+36", cyc - t0); else pass_cnt++;
        chk_cnt++; if (log_n - n0 != 16) $display("FAIL write_nibble_count: got %0d required 16", log_n - n0); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            chk_cnt++; if (log_mem[(n0 + i) % 512] !== en[i]) $display("FAIL write_nibble[%0d]: got %h required %h", i, log_mem[(n0 + i) % 512], en[i]); else pass_cnt++;
        end
        r0 = n_rsp;
        issue(1'b0, 23'h000200, 32'h0, 4'hf);
        wait_rsp(r0, ok);
        chk_cnt++; if (!ok || rsp_rdata !== 32'hDEADBEEF) $display("FAIL write_readback: got %h required deadbeef", rsp_rdata); else pass_cnt++;
        wait_ready(ok);
    endtask

    task automatic test_back_to_back();
        logic [22:0] ad [3];
        logic [31:0] ex [3];
        int  ta [3], dr [3];
        int  na = 0, nr = 0, a0 = n_acc, r0 = n_rsp;
        ad = '{23'h000104, 23'h000108, 23'h00010C};
        ex = '{32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        req_valid = 1'b1; req_write = 1'b0; req_addr = ad[0];
        for (int i = 0; i < 400 && nr < 3; i++) begin
            @(negedge clk);
            if (n_acc - a0 != na) begin
                ta[na] = t_acc; dr[na] = desel_rise; na++;
                if (na < 3) req_addr = ad[na];
                else req_valid = 1'b0;
            end
            if (n_rsp - r0 != nr) begin
                chk_cnt++; if (rsp_rdata !== ex[nr]) $display("FAIL b2b_data[%0d]: got %h required %h", nr, rsp_rdata, ex[nr]); else pass_cnt++;
                nr++;
            end
        end
        req_valid = 1'b0;
        chk_cnt++; if (na != 3 || nr != 3) $display("FAIL b2b_count: accepts=%0d rsps=%0d required 3 3", na, nr); else pass_cnt++;
        for (int k = 1; k < 3; k++) begin
            if (k < na) begin
                chk_cnt++; if (ta[k] - ta[k-1] != 49) $display("FAIL b2b_gap[%0d]: got %0d required 49", k, ta[k] - ta[k-1]); else pass_cnt++;
                chk_cnt++; if (dr[k] - dr[k-1] < 1) $display("FAIL b2b_desel[%0d]: got %0d required >=1", k, dr[k] - dr[k-1]); else pass_cnt++;
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_abort();
        int  r0 = n_rsp, t0;
        bit  ok;
        issue(1'b0, 23'h000100, 32'h0, 4'hf);
        t0 = t_acc;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_cnt++; if (cyc - t0 != 21 || psram_ncs !== 1'b1) $display("FAIL abort_ncs: ncs=%b at T+%0d required 1 at T+21", psram_ncs, cyc - t0); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        wait_ready(ok);
        repeat (30) @(negedge clk);
        chk_cnt++; if (!ok || n_rsp != r0) $display("FAIL abort_no_rsp: rsps=%0d required 0", n_rsp - r0); else pass_cnt++;
        issue(1'b0, 23'h000110, 32'h0, 4'hf);
        wait_rsp(r0, ok);
        chk_cnt++; if (!ok || rsp_rdata !== 32'h13121110) $display("FAIL abort_next_read: got %h required 13121110", rsp_rdata); else pass_cnt++;
        wait_ready(ok);
    endtask

`ifdef PSRAM_WSTRB_EN
    task automatic test_wstrb();
        logic [3:0] en [22];
        int  n0 = log_n, r0 = n_rsp, t0;
        bit  ok, sclk_seen = 1'b0;
        en = '{4'h3, 4'h8, 4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h4, 4'h4, 4'h3, 4'h3,
               4'h3, 4'h8, 4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 4'h3, 4'h1, 4'h1};
        issue(1'b1, 23'h000300, 32'h11223344, 4'b1011);
        wait_rsp(r0, ok);
        wait_ready(ok);
        repeat (5) @(negedge clk);
        chk_cnt++; if (!ok || n_rsp - r0 != 1) $display("FAIL wstrb_rsp_count: got %0d required 1", n_rsp - r0); else pass_cnt++;
        chk_cnt++; if (log_n - n0 != 22) $display("FAIL wstrb_nibble_count: got %0d required 22", log_n - n0); else pass_cnt++;
        for (int i = 0; i < 22; i++) begin
            chk_cnt++; if (log_mem[(n0 + i) % 512] !== en[i]) $display("FAIL wstrb_nibble[%0d]: got %h required %h", i, log_mem[(n0 + i) % 512], en[i]); else pass_cnt++;
        end
        r0 = n_rsp;
        issue(1'b0, 23'h000300, 32'h0, 4'h0);
        wait_rsp(r0, ok);
        chk_cnt++; if (!ok || rsp_rdata !== 32'h11023344) $display("FAIL wstrb_readback: got %h required 11023344", rsp_rdata); else pass_cnt++;
        wait_ready(ok);
        n0 = log_n; r0 = n_rsp;
        issue(1'b1, 23'h000400, 32'hCAFEF00D, 4'h0);
        t0 = t_acc;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (psram_sclk || !psram_ncs) sclk_seen = 1'b1;
        end
        chk_cnt++; if (n_rsp - r0 != 1 || t_rsp - t0 != 1) $display("FAIL wstrb0_rsp: count=%0d at T+%0d required 1 at T+1", n_rsp - r0, t_rsp - t0); else pass_cnt++;
        chk_cnt++; if (sclk_seen || log_n != n0) $display("FAIL wstrb0_bus: activity=%0d nibbles=%0d required 0 0", sclk_seen, log_n - n0); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_back_to_back();
        test_abort();
`ifdef PSRAM_WSTRB_EN
        test_wstrb();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
